// File: rtl/alu_iter_core.sv
// ALU with 1-cycle ops and an iterative shift-add MUL that exists only when `ALU_ITER_MUL_EN is defined.
// Latency 1 cycle (MUL: WIDTH+1); START is ignored while BUSY, so the caller must wait for BUSY=0.
module alu_iter_core #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [3:0]       OPCODE,
    input  logic             S,
    input  logic [WIDTH-1:0] SR1,
    input  logic [WIDTH-1:0] SR2,
    input  logic [SW-1:0]    N,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [3:0]       NZCV
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    state_t state;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [SW-1:0]    n_neg;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             op_valid;
    logic             op_wr_res;
    logic [3:0]       nzcv_next;

    always_comb begin
        add_sum   = {1'b0, SR1} + {1'b0, SR2};
        sub_sum   = {1'b0, SR1} + {1'b0, ~SR2} + {{WIDTH{1'b0}}, 1'b1};
        // WIDTH is a power of two, so WIDTH-N wraps to -N in SW bits
        n_neg     = SW'(0) - N;
        alu_res   = RESULT;
        alu_c     = NZCV[1];
        alu_v     = NZCV[0];
        op_valid  = 1'b1;
        op_wr_res = 1'b1;
        case (OPCODE)
            4'd0: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (SR1[WIDTH-1] == SR2[WIDTH-1]) && (add_sum[WIDTH-1] != SR1[WIDTH-1]);
            end
            4'd1, 4'd10: begin
                alu_res   = sub_sum[WIDTH-1:0];
                alu_c     = sub_sum[WIDTH];
                alu_v     = (SR1[WIDTH-1] != SR2[WIDTH-1]) && (sub_sum[WIDTH-1] != SR1[WIDTH-1]);
                op_wr_res = (OPCODE == 4'd1);
            end
            4'd3: alu_res = SR1 & SR2;
            4'd4: alu_res = SR1 | SR2;
            4'd5: alu_res = SR1 ^ SR2;
            4'd6: alu_res = SR2 << N;
            4'd7: alu_res = SR2 >> N;
            4'd8: alu_res = (N == '0) ? SR2 : ((SR2 >> N) | (SR2 << n_neg));
            4'd9: alu_res = SR2;
            default: begin
                op_valid  = 1'b0;
                op_wr_res = 1'b0;
            end
        endcase
        nzcv_next = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
    end

`ifdef ALU_ITER_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SW-1:0]    cnt;
    logic             s_q;

    always_comb acc_next = mplier[0] ? acc + mcand : acc;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
            NZCV   <= '0;
`ifdef ALU_ITER_MUL_EN
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            s_q    <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
`ifdef ALU_ITER_MUL_EN
                        if (OPCODE == 4'd2) begin
                            state  <= S_MUL;
                            BUSY   <= 1'b1;
                            mcand  <= SR1;
                            mplier <= SR2;
                            acc    <= '0;
                            cnt    <= '0;
                            s_q    <= S;
                        end else
`endif
                        begin
                            state <= S_DONE;
                            BUSY  <= 1'b1;
                            DONE  <= 1'b1;
                            if (op_wr_res) RESULT <= alu_res;
                            if (op_valid && (S || OPCODE == 4'd10)) NZCV <= nzcv_next;
                        end
                    end
                end
`ifdef ALU_ITER_MUL_EN
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SW'(WIDTH - 1)) begin
                        state  <= S_DONE;
                        DONE   <= 1'b1;
                        RESULT <= acc_next;
                        if (s_q) NZCV[3:2] <= {acc_next[WIDTH-1], acc_next == '0};
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end
endmodule
